mc_control: RTL and testbench

Multicycle control unit for the MIPS CPU core. It sequences the shared datapath (single memory port, single ALU, PC/IR/ALUOut registers) through fetch, decode, execute, memory and write-back states, and drives every datapath enable and mux select. It also exposes a retired-instruction counter and a halt flag so the top-level `experiment` LED/SEL display can show progress. It sits between the instruction register and the datapath, and is the only block that issues write enables.

---
 rtl/mc_pkg.sv | 59 +++++
 rtl/mc_control_alu_decoder.sv | 32 +++
 rtl/mc_control.sv | 190 +++++++++++++++++++
 tb/tb_mc_control.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared constants for the multicycle MIPS control unit:
// state encodings, opcode/funct codes, ALU controls and mux selects.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_HALT    = 4'd12
    } state_e;

    // What the ALU is being used for in a given state.
    typedef enum logic [1:0] {
        AC_NONE  = 2'd0,
        AC_ADD   = 2'd1,
        AC_SUB   = 2'd2,
        AC_FUNCT = 2'd3
    } alu_class_e;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_J    = 6'h02;

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] SRCB_B     = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_IMMSH = 2'd3;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

endpackage

// File: rtl/mc_control_alu_decoder.sv
// Combinational ALU control decode from the state's ALU usage
// class and the R-type funct field.
module alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] cls_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_ctrl_o,
    output logic       illegal_o
);

    always_comb begin
        alu_ctrl_o = ALU_AND;
        illegal_o  = 1'b0;
        case (alu_class_e'(cls_i))
            AC_ADD: alu_ctrl_o = ALU_ADD;
            AC_SUB: alu_ctrl_o = ALU_SUB;
            AC_FUNCT: begin
                case (funct_i)
                    F_ADD, F_ADDU: alu_ctrl_o = ALU_ADD;
                    F_SUB, F_SUBU: alu_ctrl_o = ALU_SUB;
                    F_AND:         alu_ctrl_o = ALU_AND;
                    F_OR:          alu_ctrl_o = ALU_OR;
                    F_SLT:         alu_ctrl_o = ALU_SLT;
                    default:       illegal_o  = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM: sequences the shared datapath and
// keeps a retired-instruction counter and a sticky halt flag.
module mc_control
    import mc_pkg::*;
#(
    parameter logic MEM_WAIT_EN = 1'b1,
    parameter int   CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_ctrl,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             halted
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             halted_q, halted_d;

    logic       ready;
    logic       illegal;
    logic [1:0] alu_cls;
    logic [3:0] alu_ctrl_c;

    logic       pc_write_c, i_or_d_c, mem_read_c, mem_write_c;
    logic       ir_write_c, reg_write_c, reg_dst_c, mem_to_reg_c;
    logic       alu_src_a_c;
    logic [1:0] pc_src_c, alu_src_b_c;

    assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

    alu_decoder u_alu_dec (
        .cls_i      (alu_cls),
        .funct_i    (funct),
        .alu_ctrl_o (alu_ctrl_c),
        .illegal_o  (illegal)
    );

    always_comb begin
        state_d      = state_q;
        alu_cls      = AC_NONE;
        pc_write_c   = 1'b0;
        pc_src_c     = PC_ALU;
        i_or_d_c     = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = SRCB_B;
        unique case (state_q)
            S_FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = SRCB_FOUR;
                alu_cls     = AC_ADD;
                if (ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b_c = SRCB_IMMSH;
                alu_cls     = AC_ADD;
                case (opcode)
                    OP_R:         state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = SRCB_IMM;
                alu_cls     = AC_ADD;
                state_d     = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read_c = 1'b1;
                i_or_d_c   = 1'b1;
                if (ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                mem_write_c = 1'b1;
                i_or_d_c    = 1'b1;
                if (ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a_c = 1'b1;
                alu_cls     = AC_FUNCT;
                state_d     = illegal ? S_HALT : S_RTYPEWB;
            end
            S_RTYPEWB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_c = 1'b1;
                alu_cls     = AC_SUB;
                pc_src_c    = PC_ALUOUT;
                pc_write_c  = alu_zero;
                state_d     = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = SRCB_IMM;
                alu_cls     = AC_ADD;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                pc_write_c = 1'b1;
                pc_src_c   = PC_JUMP;
                state_d    = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // Only completing states ever transition into FETCH.
    always_comb begin
        retired_d = retired_q;
        halted_d  = halted_q;
        if (state_d == S_FETCH && state_q != S_FETCH)
            retired_d = retired_q + 1'b1;
        if (state_d == S_HALT)
            halted_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            halted_q  <= halted_d;
        end
    end

    // Reset holds FETCH, so gate controls to keep strobes quiet.
    assign pc_write   = RST & pc_write_c;
    assign i_or_d     = RST & i_or_d_c;
    assign mem_read   = RST & mem_read_c;
    assign mem_write  = RST & mem_write_c;
    assign ir_write   = RST & ir_write_c;
    assign reg_write  = RST & reg_write_c;
    assign reg_dst    = RST & reg_dst_c;
    assign mem_to_reg = RST & mem_to_reg_c;
    assign alu_src_a  = RST & alu_src_a_c;
    assign pc_src     = RST ? pc_src_c    : 2'b00;
    assign alu_src_b  = RST ? alu_src_b_c : 2'b00;
    assign alu_ctrl   = RST ? alu_ctrl_c  : 4'b0000;

    assign state   = state_q;
    assign retired = retired_q;
    assign halted  = halted_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: each task walks one instruction
// class cycle by cycle against hand-derived state/control values.
module tb_mc_control;

    logic       CLK, RST;
    logic [5:0] opcode, funct;
    logic       alu_zero, mem_ready;
    logic       pc_write, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a, halted;
    logic [1:0] pc_src, alu_src_b;
    logic [3:0] alu_ctrl, state, retired;

    int errs = 0;
    int nchk = 0;
    logic [3:0] exp_ret;

    mc_control #(.MEM_WAIT_EN(1'b1), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .state(state), .retired(retired), .halted(halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cyc;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b0; opcode = 6'h00; funct = 6'h00;
        alu_zero = 1'b0; mem_ready = 1'b1;
        #2;
        nchk++;
        if (state !== 4'd0) begin
            errs++; $display("FAIL reset_state: got %0d exp 0", state);
        end
        nchk++;
        if ({pc_write, ir_write, reg_write, mem_write, mem_read} !== 5'b0) begin
            errs++; $display("FAIL reset_enables: got %b exp 00000",
                {pc_write, ir_write, reg_write, mem_write, mem_read});
        end
        nchk++;
        if (alu_src_b !== 2'd0 || alu_ctrl !== 4'd0) begin
            errs++; $display("FAIL reset_selects: got srcb=%0d ctrl=%b exp 0/0000",
                alu_src_b, alu_ctrl);
        end
        nchk++;
        if (retired !== 4'd0 || halted !== 1'b0) begin
            errs++; $display("FAIL reset_cnt: got ret=%0d halt=%b exp 0/0", retired, halted);
        end
        cyc(); cyc();
        RST = 1'b1;
        exp_ret = 4'd0;
        #1;
        nchk++;
        if (mem_read !== 1'b1 || alu_src_b !== 2'd1 || alu_ctrl !== 4'b0010) begin
            errs++; $display("FAIL fetch_ctrl: got rd=%b srcb=%0d ctrl=%b exp 1/1/0010",
                mem_read, alu_src_b, alu_ctrl);
        end
    endtask

    task automatic test_lw;
        logic [3:0] st[5];
        st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        opcode = 6'h23; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nchk++;
            if (state !== st[i]) begin
                errs++; $display("FAIL lw_state%0d: got %0d exp %0d", i, state, st[i]);
            end
            nchk++;
            if (reg_write !== (st[i] == 4'd4)) begin
                errs++; $display("FAIL lw_regwr%0d: got %b exp %b", i, reg_write, st[i] == 4'd4);
            end
            if (st[i] == 4'd4) begin
                nchk++;
                if (mem_to_reg !== 1'b1 || reg_dst !== 1'b0) begin
                    errs++; $display("FAIL lw_wb: got m2r=%b dst=%b exp 1/0", mem_to_reg, reg_dst);
                end
            end
            if (st[i] == 4'd3) begin
                nchk++;
                if (mem_read !== 1'b1 || i_or_d !== 1'b1) begin
                    errs++; $display("FAIL lw_memrd: got rd=%b iord=%b exp 1/1", mem_read, i_or_d);
                end
            end
            cyc();
        end
        exp_ret = exp_ret + 1'b1;
        nchk++;
        if (state !== 4'd0 || retired !== exp_ret) begin
            errs++; $display("FAIL lw_done: got st=%0d ret=%0d exp 0/%0d", state, retired, exp_ret);
        end
    endtask

    task automatic test_sw_wait;
        logic [3:0] st[6];
        logic       rdy[6];
        st  = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        opcode = 6'h2B;
        for (int i = 0; i < 6; i++) begin
            mem_ready = rdy[i];
            #1;
            nchk++;
            if (state !== st[i]) begin
                errs++; $display("FAIL sw_state%0d: got %0d exp %0d", i, state, st[i]);
            end
            nchk++;
            if (mem_write !== (st[i] == 4'd5)) begin
                errs++; $display("FAIL sw_memwr%0d: got %b exp %b", i, mem_write, st[i] == 4'd5);
            end
            cyc();
        end
        mem_ready = 1'b1;
        exp_ret = exp_ret + 1'b1;
        nchk++;
        if (state !== 4'd0 || retired !== exp_ret) begin
            errs++; $display("FAIL sw_done: got st=%0d ret=%0d exp 0/%0d", state, retired, exp_ret);
        end
    endtask

    task automatic test_beq;
        logic [3:0] st[3];
        st = '{4'd0, 4'd1, 4'd8};
        opcode = 6'h04; mem_ready = 1'b1;
        for (int z = 1; z >= 0; z--) begin
            for (int i = 0; i < 3; i++) begin
                alu_zero = (z == 1);
                #1;
                nchk++;
                if (state !== st[i]) begin
                    errs++; $display("FAIL beq%0d_state%0d: got %0d exp %0d", z, i, state, st[i]);
                end
                if (st[i] == 4'd8) begin
                    nchk++;
                    if (pc_write !== (z == 1) || pc_src !== 2'd1 || alu_ctrl !== 4'b0110) begin
                        errs++; $display("FAIL beq%0d_ctrl: got pcw=%b src=%0d ctrl=%b exp %0d/1/0110",
                            z, pc_write, pc_src, alu_ctrl, z);
                    end
                end
                cyc();
            end
            exp_ret = exp_ret + 1'b1;
            nchk++;
            if (state !== 4'd0 || retired !== exp_ret) begin
                errs++; $display("FAIL beq%0d_done: got st=%0d ret=%0d exp 0/%0d",
                    z, state, retired, exp_ret);
            end
        end
        alu_zero = 1'b0;
    endtask

    task automatic test_addi_fetch_wait;
        logic [3:0] st[5];
        logic       rdy[5];
        st  = '{4'd0, 4'd0, 4'd1, 4'd9, 4'd10};
        rdy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        opcode = 6'h08;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy[i];
            #1;
            nchk++;
            if (state !== st[i]) begin
                errs++; $display("FAIL addi_state%0d: got %0d exp %0d", i, state, st[i]);
            end
            if (st[i] == 4'd0) begin
                nchk++;
                if (ir_write !== rdy[i] || pc_write !== rdy[i]) begin
                    errs++; $display("FAIL addi_fetch%0d: got irw=%b pcw=%b exp %b",
                        i, ir_write, pc_write, rdy[i]);
                end
            end
            if (st[i] == 4'd9) begin
                nchk++;
                if (alu_src_a !== 1'b1 || alu_src_b !== 2'd2 || alu_ctrl !== 4'b0010) begin
                    errs++; $display("FAIL addi_ex: got a=%b b=%0d ctrl=%b exp 1/2/0010",
                        alu_src_a, alu_src_b, alu_ctrl);
                end
            end
            if (st[i] == 4'd10) begin
                nchk++;
                if (reg_write !== 1'b1 || reg_dst !== 1'b0 || mem_to_reg !== 1'b0) begin
                    errs++; $display("FAIL addi_wb: got rw=%b dst=%b m2r=%b exp 1/0/0",
                        reg_write, reg_dst, mem_to_reg);
                end
            end
            cyc();
        end
        exp_ret = exp_ret + 1'b1;
        nchk++;
        if (state !== 4'd0 || retired !== exp_ret) begin
            errs++; $display("FAIL addi_done: got st=%0d ret=%0d exp 0/%0d", state, retired, exp_ret);
        end
    endtask

    task automatic test_rtype_halt;
        opcode = 6'h00; funct = 6'h2A; mem_ready = 1'b1;
        cyc(); cyc();
        nchk++;
        if (state !== 4'd6 || alu_ctrl !== 4'b0111 || alu_src_a !== 1'b1 || alu_src_b !== 2'd0) begin
            errs++; $display("FAIL slt_exec: got st=%0d ctrl=%b a=%b b=%0d exp 6/0111/1/0",
                state, alu_ctrl, alu_src_a, alu_src_b);
        end
        cyc();
        nchk++;
        if (state !== 4'd7 || reg_dst !== 1'b1 || reg_write !== 1'b1 || mem_to_reg !== 1'b0) begin
            errs++; $display("FAIL slt_wb: got st=%0d dst=%b rw=%b m2r=%b exp 7/1/1/0",
                state, reg_dst, reg_write, mem_to_reg);
        end
        cyc();
        exp_ret = exp_ret + 1'b1;
        nchk++;
        if (state !== 4'd0 || retired !== exp_ret) begin
            errs++; $display("FAIL slt_done: got st=%0d ret=%0d exp 0/%0d", state, retired, exp_ret);
        end
        funct = 6'h22;
        cyc(); cyc();
        nchk++;
        if (alu_ctrl !== 4'b0110) begin
            errs++; $display("FAIL sub_exec: got %b exp 0110", alu_ctrl);
        end
        cyc(); cyc();
        exp_ret = exp_ret + 1'b1;
        funct = 6'h3F;
        cyc(); cyc();
        nchk++;
        if (state !== 4'd6 || halted !== 1'b0 || reg_write !== 1'b0) begin
            errs++; $display("FAIL bad_exec: got st=%0d halt=%b rw=%b exp 6/0/0", state, halted, reg_write);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            nchk++;
            if (state !== 4'd12 || halted !== 1'b1 || reg_write !== 1'b0 ||
                mem_read !== 1'b0 || pc_write !== 1'b0 || retired !== exp_ret) begin
                errs++; $display("FAIL halt%0d: got st=%0d halt=%b rw=%b rd=%b pcw=%b ret=%0d exp 12/1/0/0/0/%0d",
                    i, state, halted, reg_write, mem_read, pc_write, retired, exp_ret);
            end
        end
        funct = 6'h20;
    endtask

    task automatic test_reset_mid;
        RST = 1'b0;
        #1;
        nchk++;
        if (state !== 4'd0 || halted !== 1'b0 || retired !== 4'd0) begin
            errs++; $display("FAIL unhalt: got st=%0d halt=%b ret=%0d exp 0/0/0", state, halted, retired);
        end
        cyc();
        RST = 1'b1;
        exp_ret = 4'd0;
        opcode = 6'h23; mem_ready = 1'b1;
        cyc(); cyc(); cyc();
        mem_ready = 1'b0;
        cyc();
        nchk++;
        if (state !== 4'd3 || mem_read !== 1'b1) begin
            errs++; $display("FAIL mid_hold: got st=%0d rd=%b exp 3/1", state, mem_read);
        end
        mem_ready = 1'b1;
        RST = 1'b0;
        #1;
        nchk++;
        if (state !== 4'd0 || {pc_write, ir_write, reg_write, mem_write, mem_read} !== 5'b0 ||
            i_or_d !== 1'b0 || retired !== 4'd0) begin
            errs++; $display("FAIL mid_reset: got st=%0d en=%b iord=%b ret=%0d exp 0/00000/0/0",
                state, {pc_write, ir_write, reg_write, mem_write, mem_read}, i_or_d, retired);
        end
        cyc();
        RST = 1'b1;
        #1;
    endtask

    task automatic test_jump_wrap;
        logic [3:0] st[3];
        st = '{4'd0, 4'd1, 4'd11};
        opcode = 6'h02; mem_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < 3; i++) begin
                nchk++;
                if (state !== st[i]) begin
                    errs++; $display("FAIL j%0d_state%0d: got %0d exp %0d", n, i, state, st[i]);
                end
                if (st[i] == 4'd11) begin
                    nchk++;
                    if (pc_write !== 1'b1 || pc_src !== 2'd2) begin
                        errs++; $display("FAIL j%0d_ctrl: got pcw=%b src=%0d exp 1/2", n, pc_write, pc_src);
                    end
                end
                cyc();
            end
            exp_ret = exp_ret + 1'b1;
            nchk++;
            if (retired !== exp_ret) begin
                errs++; $display("FAIL j%0d_ret: got %0d exp %0d", n, retired, exp_ret);
            end
        end
        nchk++;
        if (retired !== 4'd0) begin
            errs++; $display("FAIL j_wrap: got %0d exp 0", retired);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_beq();
        test_addi_fetch_wait();
        test_rtype_halt();
        test_reset_mid();
        test_jump_wrap();
        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
